// File: rtl/slave_regfile_cmd_fifo.sv
// -----------------------------------------------------------------------------
// slave_regfile_cmd_fifo
//
// Slave-side register file with a command FIFO, sitting in front of the user
// logic that polls it.
//   * Slave writes update NUMREGS word registers with per-byte enables.
//   * The user logic reads any register combinationally through data_addr.
//   * Every write to the command register index pushes the merged
//     (post-byte-enable) word into a first-word-fall-through FIFO. The user
//     logic drains that FIFO through the r_fifo_* port.
//   * Index STATUS_REG_INDEX is a read-only status word:
//       [0] empty, [1] full, [2] overflow, [3 +: CW] count, other bits 0.
//     A slave read of it clears the sticky overflow flag.
//
// Optional feature (compile-time macro CMD_FIFO_FLUSH_EN):
//   When defined, a slave write to STATUS_REG_INDEX with byte_en[0]=1 and
//   data[0]=1 flushes the FIFO (both pointers and overflow cleared).
//   When undefined, status writes are ignored and no flush logic exists.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   slave_write_en/addr/data     slave write strobe, byte address, data
//   slave_byte_en                per-byte write enables
//   slave_read_en/addr           slave read strobe and byte address
//   slave_read_data              read data, registered (latency 1)
//   data_addr, data              user word index and combinational data
//   r_fifo_read_enable           pop request
//   r_fifo_read_data             head word (0 while empty)
//   r_fifo_empty/full            FIFO flags
//   r_fifo_overflow              sticky: a push was dropped
//   r_fifo_count                 FIFO occupancy
// -----------------------------------------------------------------------------
module slave_regfile_cmd_fifo #(
  parameter int ADDRESSWIDTH     = 32,
  parameter int DATAWIDTH        = 32,
  parameter int BYTEENABLEWIDTH  = 4,
  parameter int NUMREGS          = 32,
  parameter int FIFO_DEPTH       = 8,
  parameter int CMD_REG_INDEX    = 0,
  parameter int STATUS_REG_INDEX = NUMREGS - 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          slave_write_en,
  input  logic [ADDRESSWIDTH-1:0]       slave_write_addr,
  input  logic [DATAWIDTH-1:0]          slave_write_data,
  input  logic [BYTEENABLEWIDTH-1:0]    slave_byte_en,
  input  logic                          slave_read_en,
  input  logic [ADDRESSWIDTH-1:0]       slave_read_addr,
  output logic [DATAWIDTH-1:0]          slave_read_data,
  input  logic [ADDRESSWIDTH-1:0]       data_addr,
  output logic [DATAWIDTH-1:0]          data,
  input  logic                          r_fifo_read_enable,
  output logic [DATAWIDTH-1:0]          r_fifo_read_data,
  output logic                          r_fifo_empty,
  output logic                          r_fifo_full,
  output logic                          r_fifo_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   r_fifo_count
);

  localparam int IDXW = $clog2(NUMREGS);
  localparam int IDXF = $clog2(FIFO_DEPTH);
  localparam int CW   = IDXF + 1;

  localparam logic [IDXW-1:0] CMD_IDX    = IDXW'(CMD_REG_INDEX);
  localparam logic [IDXW-1:0] STATUS_IDX = IDXW'(STATUS_REG_INDEX);

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [DATAWIDTH-1:0] regs     [NUMREGS];
  logic [DATAWIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [CW-1:0]        wptr, rptr;
  logic [CW-1:0]        wptr_nxt, rptr_nxt;
  logic                 overflow, overflow_nxt;

  // ---------------------------------------------------------------------------
  // Address decode. Byte addresses map to word indices; upper bits are
  // dropped so the slave index wraps modulo NUMREGS.
  // ---------------------------------------------------------------------------
  logic [IDXW-1:0] wr_idx, rd_idx, usr_idx;

  assign wr_idx  = slave_write_addr[IDXW+1:2];
  assign rd_idx  = slave_read_addr[IDXW+1:2];
  assign usr_idx = data_addr[IDXW-1:0];

  // Address bits that carry no meaning for this block.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{slave_write_addr[ADDRESSWIDTH-1:IDXW+2],
                              slave_write_addr[1:0],
                              slave_read_addr[ADDRESSWIDTH-1:IDXW+2],
                              slave_read_addr[1:0],
                              data_addr[ADDRESSWIDTH-1:IDXW]};

  // ---------------------------------------------------------------------------
  // Byte-lane merge: the word a write leaves behind in the register. The same
  // merged word is what a command write pushes into the FIFO.
  // ---------------------------------------------------------------------------
  logic [DATAWIDTH-1:0] wr_merged;

  // NOTE: every variable written in an always_comb gets a default assignment
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_merged = regs[wr_idx];
    for (int b = 0; b < BYTEENABLEWIDTH; b++) begin
      if (slave_byte_en[b]) begin
        wr_merged[8*b +: 8] = slave_write_data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO flags and status word
  // ---------------------------------------------------------------------------
  assign r_fifo_empty    = (wptr == rptr);
  assign r_fifo_full     = (wptr[IDXF] != rptr[IDXF]) &&
                           (wptr[IDXF-1:0] == rptr[IDXF-1:0]);
  assign r_fifo_count    = wptr - rptr;
  assign r_fifo_overflow = overflow;

  logic [DATAWIDTH-1:0] status_word;

  always_comb begin
    status_word         = '0;
    status_word[0]      = r_fifo_empty;
    status_word[1]      = r_fifo_full;
    status_word[2]      = overflow;
    status_word[3 +: CW] = r_fifo_count;
  end

  // Fall-through head; forced to 0 so stale storage never leaks out.
  assign r_fifo_read_data = r_fifo_empty ? '0 : fifo_mem[rptr[IDXF-1:0]];

  // User data port: status index shows the live status word.
  assign data = (usr_idx == STATUS_IDX) ? status_word : regs[usr_idx];

  // ---------------------------------------------------------------------------
  // Push / pop decision
  // ---------------------------------------------------------------------------
  logic push_req, pop, push_ok, drop, status_rd;

  assign push_req  = slave_write_en && (wr_idx == CMD_IDX) && (|slave_byte_en);
  // A pop against an empty FIFO is ignored, which also covers the case of a
  // pop arriving alongside the push that fills an empty FIFO.
  assign pop       = r_fifo_read_enable && !r_fifo_empty;
  // When full, a concurrent pop frees the slot the push needs.
  assign push_ok   = push_req && (!r_fifo_full || pop);
  assign drop      = push_req && r_fifo_full && !pop;
  assign status_rd = slave_read_en && (rd_idx == STATUS_IDX);

`ifdef CMD_FIFO_FLUSH_EN
  logic flush;
  assign flush = slave_write_en && (wr_idx == STATUS_IDX) &&
                 slave_byte_en[0] && slave_write_data[0];
`endif

  always_comb begin
    wptr_nxt     = push_ok ? wptr + CW'(1) : wptr;
    rptr_nxt     = pop     ? rptr + CW'(1) : rptr;
    overflow_nxt = overflow;
    // A drop on the same edge as a status read wins: the flag stays set.
    if (drop) begin
      overflow_nxt = 1'b1;
    end else if (status_rd) begin
      overflow_nxt = 1'b0;
    end
`ifdef CMD_FIFO_FLUSH_EN
    // Flush overrides any same-cycle pop.
    if (flush) begin
      wptr_nxt     = '0;
      rptr_nxt     = '0;
      overflow_nxt = 1'b0;
    end
`endif
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      wptr     <= wptr_nxt;
      rptr     <= rptr_nxt;
      overflow <= overflow_nxt;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers define which entries are
  // valid and the head output is gated by empty. The register file, by
  // contrast, is directly observable and therefore must clear on reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wptr[IDXF-1:0]] <= wr_merged;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file. The status index has no writable storage.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUMREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (slave_write_en && (wr_idx != STATUS_IDX)) begin
      regs[wr_idx] <= wr_merged;
    end
  end

  // ---------------------------------------------------------------------------
  // Slave read port, latency 1. Reads sample pre-edge storage, so a
  // same-cycle write to the same index returns the old value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slave_read_data <= '0;
    end else if (slave_read_en) begin
      slave_read_data <= (rd_idx == STATUS_IDX) ? status_word : regs[rd_idx];
    end
  end

endmodule

// File: tb/tb_slave_regfile_cmd_fifo.sv
// -----------------------------------------------------------------------------
// Testbench for slave_regfile_cmd_fifo (default parameters).
// A reference model (register array plus a queue holding the expected FIFO
// contents) is updated as stimulus is driven; popped words are compared to
// the queue head, and flags/count/read data are compared after each edge.
// Inputs change on the falling edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_slave_regfile_cmd_fifo;

  localparam int  DEPTH      = 8;
  localparam int  STATUS_IDX = 31;
  localparam logic [31:0] STATUS_ADDR = 32'h7C;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        slave_write_en;
  logic [31:0] slave_write_addr;
  logic [31:0] slave_write_data;
  logic [3:0]  slave_byte_en;
  logic        slave_read_en;
  logic [31:0] slave_read_addr;
  logic [31:0] slave_read_data;
  logic [31:0] data_addr;
  logic [31:0] data;
  logic        r_fifo_read_enable;
  logic [31:0] r_fifo_read_data;
  logic        r_fifo_empty;
  logic        r_fifo_full;
  logic        r_fifo_overflow;
  logic [3:0]  r_fifo_count;

  slave_regfile_cmd_fifo dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .slave_write_en     (slave_write_en),
    .slave_write_addr   (slave_write_addr),
    .slave_write_data   (slave_write_data),
    .slave_byte_en      (slave_byte_en),
    .slave_read_en      (slave_read_en),
    .slave_read_addr    (slave_read_addr),
    .slave_read_data    (slave_read_data),
    .data_addr          (data_addr),
    .data               (data),
    .r_fifo_read_enable (r_fifo_read_enable),
    .r_fifo_read_data   (r_fifo_read_data),
    .r_fifo_empty       (r_fifo_empty),
    .r_fifo_full        (r_fifo_full),
    .r_fifo_overflow    (r_fifo_overflow),
    .r_fifo_count       (r_fifo_count)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [31:0] m_regs [32];
  logic [31:0] sb [$];
  logic        m_ovf;
  logic [31:0] exp_rd;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    int n;
    n    = sb.size();
    s    = '0;
    s[0] = (n == 0);
    s[1] = (n == DEPTH);
    s[2] = m_ovf;
    s[6:3] = 4'(n);
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    sb.delete();
    m_ovf  = 1'b0;
    exp_rd = '0;
  endtask

  // One clock cycle of stimulus; the model advances with the same edge.
  task automatic cycle(input bit we, input logic [31:0] waddr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input bit re, input logic [31:0] raddr, input bit pop_req);
    int          widx, ridx, pre_n;
    bit          push, pop_ok, push_ok, drop;
    logic [31:0] merged;
    slave_write_en     = we;
    slave_write_addr   = waddr;
    slave_write_data   = wdata;
    slave_byte_en      = be;
    slave_read_en      = re;
    slave_read_addr    = raddr;
    r_fifo_read_enable = pop_req;
    #1;
    widx   = int'(waddr[6:2]);
    ridx   = int'(raddr[6:2]);
    pre_n  = sb.size();
    merged = m_regs[widx];
    for (int b = 0; b < 4; b++)
      if (be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    if (re) exp_rd = (ridx == STATUS_IDX) ? m_status() : m_regs[ridx];
    push    = we && (widx == 0) && (be != 4'h0);
    pop_ok  = pop_req && (pre_n != 0);
    push_ok = push && (pre_n < DEPTH || pop_ok);
    drop    = push && (pre_n == DEPTH) && !pop_ok;
    if (pop_ok) begin
      check("pop_data", r_fifo_read_data, sb[0]);
      void'(sb.pop_front());
    end
    if (push_ok) sb.push_back(merged);
    if (drop) m_ovf = 1'b1;
    else if (re && ridx == STATUS_IDX) m_ovf = 1'b0;
`ifdef CMD_FIFO_FLUSH_EN
    if (we && widx == STATUS_IDX && be[0] && wdata[0]) begin
      sb.delete();
      m_ovf = 1'b0;
    end
`endif
    if (we && widx != STATUS_IDX) m_regs[widx] = merged;
    @(posedge clk);
    @(negedge clk);
    slave_write_en     = 1'b0;
    slave_byte_en      = 4'h0;
    slave_read_en      = 1'b0;
    r_fifo_read_enable = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d,
                    input logic [3:0] be);
    cycle(1'b1, addr, d, be, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic check_state(input string tag);
    int n;
    n = sb.size();
    check({tag, ":count"}, 32'(r_fifo_count), 32'(n));
    check({tag, ":empty"}, 32'(r_fifo_empty), 32'(n == 0));
    check({tag, ":full"},  32'(r_fifo_full),  32'(n == DEPTH));
    check({tag, ":ovf"},   32'(r_fifo_overflow), 32'(m_ovf));
    check({tag, ":head"},  r_fifo_read_data, (n != 0) ? sb[0] : 32'h0);
    check({tag, ":rdata"}, slave_read_data, exp_rd);
  endtask

  task automatic check_data(input string tag, input int idx);
    data_addr = 32'(idx);
    #1;
    check(tag, data, (idx == STATUS_IDX) ? m_status() : m_regs[idx]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset_n            = 1'b0;
    slave_write_en     = 1'b0;
    slave_write_addr   = '0;
    slave_write_data   = '0;
    slave_byte_en      = '0;
    slave_read_en      = 1'b0;
    slave_read_addr    = '0;
    data_addr          = '0;
    r_fifo_read_enable = 1'b0;
    model_reset();

    // Reset state
    #12;
    check_state("reset");
    check_data("reset_d0", 0);
    check_data("reset_status", STATUS_IDX);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Single command push then pop
    wr(32'h0, 32'hF00BF00B, 4'hF);
    check_state("t1_push");
    check("t1_head_const", r_fifo_read_data, 32'hF00BF00B);
    cycle(1'b0, 0, 0, 4'h0, 1'b0, 0, 1'b1);
    check_state("t1_pop");

    // Byte-enable merge, no push; wrapped address
    wr(32'h8, 32'hAABBCCDD, 4'hF);
    wr(32'h8, 32'h11223344, 4'h3);
    check_data("t2_merge", 2);
    check("t2_merge_const", data, 32'hAABB3344);
    check_state("t2_nopush");
    wr(32'h88, 32'h99000000, 4'h8);
    check_data("t2_wrap", 2);
    wr(32'h0, 32'h12121212, 4'h0);
    check_state("t2_be0");

    // Fill, overflow, status reads
    for (int i = 0; i < DEPTH; i++) begin
      wr(32'h0, 32'h100 + 32'(i), 4'hF);
      check_state("t3_fill");
    end
    wr(32'h0, 32'h108, 4'hF);
    check_state("t3_drop");
    check("t3_head_first", r_fifo_read_data, 32'h100);
    check_data("t3_reg_updated", 0);
    cycle(1'b0, 0, 0, 4'h0, 1'b1, STATUS_ADDR, 1'b0);
    check_state("t3_status1");
    check("t3_status1_const", slave_read_data, 32'h46);
    cycle(1'b0, 0, 0, 4'h0, 1'b1, STATUS_ADDR, 1'b0);
    check_state("t3_status2");
    check("t3_status2_const", slave_read_data, 32'h42);
    // Drop and status read on the same edge: overflow stays set
    cycle(1'b1, 32'h0, 32'h109, 4'hF, 1'b1, STATUS_ADDR, 1'b0);
    check_state("t3_drop_wins");
    cycle(1'b0, 0, 0, 4'h0, 1'b1, STATUS_ADDR, 1'b0);
    check_state("t3_status3");

    // Full with simultaneous push and pop
    cycle(1'b1, 32'h0, 32'h200, 4'hF, 1'b0, 0, 1'b1);
    check_state("t4_pushpop");
    check("t4_head_const", r_fifo_read_data, 32'h101);

    // Drain, then pop while empty
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 0, 0, 4'h0, 1'b0, 0, 1'b1);
      check_state("t5_drain");
    end
    cycle(1'b0, 0, 0, 4'h0, 1'b0, 0, 1'b1);
    check_state("t5_pop_empty");

    // Push on empty with pop asserted
    cycle(1'b1, 32'h0, 32'hDEADF00B, 4'hF, 1'b0, 0, 1'b1);
    check_state("t6_push_empty_pop");
    check("t6_head_const", r_fifo_read_data, 32'hDEADF00B);

    // Slave read latency, same-cycle write/read, hold
    cycle(1'b0, 0, 0, 4'h0, 1'b1, 32'h8, 1'b0);
    check_state("t7_read");
    cycle(1'b1, 32'h8, 32'h12345678, 4'hF, 1'b1, 32'h8, 1'b0);
    check_state("t7_rd_old");
    check("t7_rd_old_const", slave_read_data, 32'h99BB3344);
    wr(32'h8, 32'h55555555, 4'hF);
    check_state("t7_hold");
    cycle(1'b0, 0, 0, 4'h0, 1'b1, 32'h88, 1'b0);
    check_state("t7_read_wrap");

    // Flush attempt through the status register
    wr(32'h0, 32'hA1, 4'hF);
    wr(32'h0, 32'hA2, 4'hF);
    check_state("t8_three");
    wr(STATUS_ADDR, 32'h1, 4'h1);
    check_state("t8_flush");
`ifdef CMD_FIFO_FLUSH_EN
    check("t8_flush_count", 32'(r_fifo_count), 32'd0);
`else
    check("t8_flush_count", 32'(r_fifo_count), 32'd3);
`endif
    check_data("t8_status_data", STATUS_IDX);

    // Asynchronous reset mid-stream
    wr(32'h0, 32'hB1, 4'hF);
    data_addr = 32'h2;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_state("t9_async_reset");
    check("t9_data_reg2", data, 32'h0);
    check_data("t9_status", STATUS_IDX);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_state("t9_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
